// File: rtl/mem_bus_ctrl.sv
// Registered CPU bus controller: decodes RAM/BIOS/IO regions, steers byte lanes and
// runs a request/acknowledge FSM with RAM wait states and an I/O completion timeout.
module mem_bus_ctrl #(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 16,
   parameter int BIOS_TOP   = 'h0800,
   parameter int IO_BASE    = 'hff00,
   parameter int IO_TOP     = 'hffff,
   parameter int IO_AW      = 8,
   parameter int RAM_WAIT   = 0,
   parameter int IO_TIMEOUT = 15
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_CPU_req,
   input  logic [ADDR_W-1:0] i_CPU_addr,
   input  logic              i_CPU_we,
   input  logic              i_CPU_be,
   input  logic [DATA_W-1:0] i_CPU_write,
   output logic [DATA_W-1:0] o_CPU_read,
   output logic              o_CPU_ack,
   output logic              o_CPU_err,
   input  logic              i_BIOS_ena,
   input  logic [DATA_W-1:0] i_BIOS_read,
   input  logic [DATA_W-1:0] i_RAM_read,
   output logic [ADDR_W-2:0] o_RAM_addr,
   output logic [DATA_W-1:0] o_RAM_write,
   output logic [1:0]        o_RAM_be,
   output logic              o_RAM_en,
   output logic              o_RAM_we,
   output logic [IO_AW-1:0]  o_IO_addr,
   output logic [DATA_W-1:0] o_IO_write,
   output logic              o_IO_be,
   output logic              o_IO_re,
   output logic              o_IO_we,
   input  logic [DATA_W-1:0] i_IO_read,
   input  logic              i_IO_ack
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   localparam logic [ADDR_W-1:0] BIOS_TOP_A = ADDR_W'(BIOS_TOP);
   localparam logic [ADDR_W-1:0] IO_BASE_A  = ADDR_W'(IO_BASE);
   localparam logic [ADDR_W-1:0] IO_TOP_A   = ADDR_W'(IO_TOP);

   // A byte at an odd address rides the low lane, at an even address the high lane.
   function automatic logic [1:0] lane_sel(input logic byte_acc, input logic a0);
      if (!byte_acc) return 2'b11;
      return a0 ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [DATA_W-1:0] steer_wr(input logic [DATA_W-1:0] wr,
                                                  input logic [1:0] lanes);
      case (lanes)
         2'b01:   return {8'h00, wr[7:0]};
         2'b10:   return {wr[7:0], 8'h00};
         default: return wr;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] steer_rd(input logic [DATA_W-1:0] rd,
                                                  input logic [1:0] lanes);
      case (lanes)
         2'b01:   return {8'h00, rd[7:0]};
         2'b10:   return {8'h00, rd[DATA_W-1:8]};
         default: return rd;
      endcase
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic                we_q, be_q, io_q, bios_q, err_q;
   logic [DATA_W-1:0]   wr_q, read_q;
   logic [1:0]          lanes_q;
   logic [7:0]          cnt_q;
   logic                in_io, in_bios, misalign, ram_last, io_last;

   assign in_io    = (i_CPU_addr >= IO_BASE_A) && (i_CPU_addr <= IO_TOP_A);
   assign in_bios  = i_BIOS_ena && (i_CPU_addr < BIOS_TOP_A) && !i_CPU_we;
   assign misalign = !i_CPU_be && i_CPU_addr[0];
   assign ram_last = (cnt_q == 8'(RAM_WAIT));
   assign io_last  = (cnt_q == 8'(IO_TIMEOUT - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_CPU_req) state_d = misalign ? RESP : ACCESS;
         ACCESS:  if (io_q ? (i_IO_ack || io_last) : ram_last) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_CPU_ack = 1'b0;
      o_CPU_err = 1'b0;
      o_RAM_en  = 1'b0;
      o_RAM_we  = 1'b0;
      o_IO_re   = 1'b0;
      o_IO_we   = 1'b0;
      case (state_q)
         ACCESS: begin
            o_RAM_en = !io_q;
            o_RAM_we = !io_q && we_q;
            o_IO_re  = io_q && !we_q;
            o_IO_we  = io_q && we_q;
         end
         RESP: begin
            o_CPU_ack = 1'b1;
            o_CPU_err = err_q;
         end
         default: begin
         end
      endcase
   end

   // Transaction latch, access cycle counter and read-data capture.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= 1'b0;
         wr_q    <= '0;
         io_q    <= 1'b0;
         bios_q  <= 1'b0;
         lanes_q <= 2'b00;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         read_q  <= '0;
      end else begin
         case (state_q)
            IDLE: if (i_CPU_req) begin
               addr_q  <= i_CPU_addr;
               we_q    <= i_CPU_we;
               be_q    <= i_CPU_be;
               wr_q    <= i_CPU_write;
               io_q    <= in_io;
               bios_q  <= !in_io && in_bios;
               lanes_q <= misalign ? 2'b00 : lane_sel(i_CPU_be, i_CPU_addr[0]);
               err_q   <= misalign;
               cnt_q   <= '0;
               if (misalign) read_q <= '0;
            end
            ACCESS: begin
               cnt_q <= cnt_q + 8'd1;
               if (io_q) begin
                  if (i_IO_ack) begin
                     read_q <= i_IO_read;
                     err_q  <= 1'b0;
                  end else if (io_last) begin
                     read_q <= '0;
                     err_q  <= 1'b1;
                  end
               end else if (ram_last) begin
                  read_q <= steer_rd(bios_q ? i_BIOS_read : i_RAM_read, lanes_q);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_CPU_read  = read_q;
   assign o_RAM_addr  = addr_q[ADDR_W-1:1];
   assign o_RAM_write = steer_wr(wr_q, lanes_q);
   assign o_RAM_be    = lanes_q;
   assign o_IO_addr   = addr_q[IO_AW-1:0];
   assign o_IO_write  = wr_q;
   assign o_IO_be     = be_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed and randomized transactions checked cycle by cycle
// against a transaction-level reference model.
module tb_mem_bus_ctrl;
   localparam int ADDR_W     = 19;
   localparam int DATA_W     = 16;
   localparam int BIOS_TOP   = 'h0800;
   localparam int IO_BASE    = 'hff00;
   localparam int IO_TOP     = 'hffff;
   localparam int IO_AW      = 8;
   localparam int RAM_WAIT   = 2;
   localparam int IO_TIMEOUT = 15;

   logic              clk, i_rst_n, i_CPU_req, i_CPU_we, i_CPU_be, i_BIOS_ena, i_IO_ack;
   logic [ADDR_W-1:0] i_CPU_addr;
   logic [DATA_W-1:0] i_CPU_write, i_BIOS_read, i_RAM_read, i_IO_read;
   logic [DATA_W-1:0] o_CPU_read, o_RAM_write, o_IO_write;
   logic              o_CPU_ack, o_CPU_err, o_RAM_en, o_RAM_we, o_IO_be, o_IO_re, o_IO_we;
   logic [ADDR_W-2:0] o_RAM_addr;
   logic [1:0]        o_RAM_be;
   logic [IO_AW-1:0]  o_IO_addr;

   int checks = 0;
   int errors = 0;

   mem_bus_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BIOS_TOP(BIOS_TOP), .IO_BASE(IO_BASE),
      .IO_TOP(IO_TOP), .IO_AW(IO_AW), .RAM_WAIT(RAM_WAIT), .IO_TIMEOUT(IO_TIMEOUT)
   ) dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_CPU_req(i_CPU_req), .i_CPU_addr(i_CPU_addr),
      .i_CPU_we(i_CPU_we), .i_CPU_be(i_CPU_be), .i_CPU_write(i_CPU_write),
      .o_CPU_read(o_CPU_read), .o_CPU_ack(o_CPU_ack), .o_CPU_err(o_CPU_err),
      .i_BIOS_ena(i_BIOS_ena), .i_BIOS_read(i_BIOS_read), .i_RAM_read(i_RAM_read),
      .o_RAM_addr(o_RAM_addr), .o_RAM_write(o_RAM_write), .o_RAM_be(o_RAM_be),
      .o_RAM_en(o_RAM_en), .o_RAM_we(o_RAM_we), .o_IO_addr(o_IO_addr),
      .o_IO_write(o_IO_write), .o_IO_be(o_IO_be), .o_IO_re(o_IO_re), .o_IO_we(o_IO_we),
      .i_IO_read(i_IO_read), .i_IO_ack(i_IO_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        io;
      logic        err;
      logic [1:0]  lanes;
      logic [15:0] wr;
      logic [15:0] rd;
      int          strobes;
   } exp_t;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Whole-transaction outcome; k is the access cycle on which the device answers.
   function automatic exp_t model(input logic [18:0] a, input logic we, input logic be,
                                  input logic [15:0] wr, input logic bios_ena,
                                  input logic [15:0] ram_rd, input logic [15:0] bios_rd,
                                  input logic [15:0] io_rd, input int k);
      exp_t e;
      logic [15:0] src, wbyte;
      e.io    = (a >= IO_BASE) && (a <= IO_TOP);
      e.lanes = !be ? 2'b11 : (a[0] ? 2'b01 : 2'b10);
      wbyte   = {8'h00, wr[7:0]};
      e.wr    = !be ? wr : (a[0] ? wbyte : (wbyte << 8));
      if (!be && a[0]) begin
         e.err = 1'b1; e.rd = 16'h0; e.strobes = 0;
      end else if (e.io) begin
         if (k < IO_TIMEOUT) begin
            e.err = 1'b0; e.rd = io_rd; e.strobes = k + 1;
         end else begin
            e.err = 1'b1; e.rd = 16'h0; e.strobes = IO_TIMEOUT;
         end
      end else begin
         src = (bios_ena && a < BIOS_TOP && !we) ? bios_rd : ram_rd;
         e.rd = !be ? src : (a[0] ? (src & 16'h00ff) : (src >> 8));
         e.err = 1'b0;
         e.strobes = RAM_WAIT + 1;
      end
      return e;
   endfunction

   task automatic txn(input logic [18:0] a, input logic we, input logic be,
                      input logic [15:0] wr, input logic bios_ena, input logic [15:0] ram_rd,
                      input logic [15:0] bios_rd, input logic [15:0] io_rd, input int k);
      exp_t e;
      int   scnt;
      bit   acked;
      e = model(a, we, be, wr, bios_ena, ram_rd, bios_rd, io_rd, k);
      @(negedge clk);
      i_CPU_addr = a; i_CPU_we = we; i_CPU_be = be; i_CPU_write = wr;
      i_BIOS_ena = bios_ena; i_RAM_read = ram_rd; i_BIOS_read = bios_rd;
      i_IO_read = 16'($urandom); i_IO_ack = 1'b0;
      i_CPU_req = 1'b1;
      scnt = 0;
      acked = 1'b0;
      for (int n = 1; n <= IO_TIMEOUT + RAM_WAIT + 8 && !acked; n++) begin
         @(posedge clk); #1;
         if (o_CPU_ack) begin
            acked = 1'b1;
            check("ack_latency", n, e.strobes + 1);
            check("strobe_cycles", scnt, e.strobes);
            check("read_data", o_CPU_read, e.rd);
            check("err", o_CPU_err, e.err);
            check("resp_strobes", {o_RAM_en, o_RAM_we, o_IO_re, o_IO_we}, 0);
            i_CPU_req = 1'b0;
            i_IO_ack = 1'b0;
         end else if (o_RAM_en || o_RAM_we || o_IO_re || o_IO_we) begin
            if (e.io) begin
               check("io_strobe", {o_RAM_en, o_RAM_we, o_IO_re, o_IO_we}, {2'b00, !we, we});
               check("io_addr", o_IO_addr, a[7:0]);
               check("io_write", o_IO_write, wr);
               check("io_be", o_IO_be, be);
               i_IO_ack  = (scnt == k);
               i_IO_read = (scnt == k) ? io_rd : 16'($urandom);
            end else begin
               check("ram_strobe", {o_RAM_en, o_RAM_we, o_IO_re, o_IO_we}, {1'b1, we, 2'b00});
               check("ram_addr", o_RAM_addr, a[18:1]);
               check("ram_be", o_RAM_be, e.lanes);
               check("ram_write", o_RAM_write, e.wr);
               i_IO_ack = 1'($urandom);
            end
            scnt++;
         end
      end
      if (!acked) begin
         check("ack_seen", acked, 1);
         i_CPU_req = 1'b0;
         i_IO_ack = 1'b0;
      end
      @(posedge clk); #1;
      check("ack_one_cycle", o_CPU_ack, 0);
      check("read_hold", o_CPU_read, e.rd);
   endtask

   initial begin
      i_rst_n = 1'b0; i_CPU_req = 1'b0; i_CPU_addr = '0; i_CPU_we = 1'b0; i_CPU_be = 1'b0;
      i_CPU_write = '0; i_BIOS_ena = 1'b0; i_BIOS_read = '0; i_RAM_read = '0;
      i_IO_read = '0; i_IO_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctrl", {o_CPU_ack, o_CPU_err, o_RAM_en, o_RAM_we, o_IO_re, o_IO_we, o_IO_be}, 0);
      check("rst_read", o_CPU_read, 0);
      check("rst_ram_addr", o_RAM_addr, 0);
      check("rst_ram_be", o_RAM_be, 0);
      check("rst_ram_write", o_RAM_write, 0);
      check("rst_io_addr", o_IO_addr, 0);
      check("rst_io_write", o_IO_write, 0);
      @(negedge clk);
      i_rst_n = 1'b1;

      // Directed cases
      txn(19'h00101, 1'b1, 1'b1, 16'h00AB, 1'b0, 16'h1111, 16'h0, 16'h0, 0);
      txn(19'h00100, 1'b0, 1'b1, 16'h0000, 1'b0, 16'hBEEF, 16'h0, 16'h0, 0);
      txn(19'h00010, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h5555, 16'h1234, 16'h0, 0);
      txn(19'h00010, 1'b1, 1'b0, 16'hCAFE, 1'b1, 16'h7777, 16'h1234, 16'h0, 0);
      txn(19'h00010, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h4321, 16'h1234, 16'h0, 0);
      txn(19'h0ff90, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h0055, 2);
      txn(19'h0ff80, 1'b1, 1'b0, 16'h1357, 1'b0, 16'h0, 16'h0, 16'h0, 255);
      txn(19'h0ff00, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 16'hA5A5, IO_TIMEOUT - 1);
      txn(19'h0fffe, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0, 16'h0, 16'h5A5A, IO_TIMEOUT);
      txn(19'h0ff01, 1'b1, 1'b1, 16'h00C3, 1'b0, 16'h0, 16'h0, 16'h0, 0);
      txn(19'h00003, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 16'h0, 16'h0, 0);
      txn(19'h0feff, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h9876, 16'h0, 16'h0, 0);
      txn(19'h10000, 1'b1, 1'b0, 16'h2468, 1'b0, 16'h0246, 16'h0, 16'h0, 0);
      txn(19'h007fe, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111, 16'hB105, 16'h0, 0);
      txn(19'h00800, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 16'hB105, 16'h0, 0);

      // Reset in the middle of a RAM access aborts without an ack
      @(negedge clk);
      i_CPU_addr = 19'h00200; i_CPU_we = 1'b1; i_CPU_be = 1'b0; i_CPU_write = 16'hDEAD;
      i_BIOS_ena = 1'b0; i_CPU_req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #2;
      check("pre_reset_en", o_RAM_en, 1);
      i_rst_n = 1'b0;
      #1;
      check("rst_mid_en", {o_RAM_en, o_RAM_we}, 0);
      check("rst_mid_ack", o_CPU_ack, 0);
      check("rst_mid_read", o_CPU_read, 0);
      i_CPU_req = 1'b0;
      @(negedge clk);
      i_rst_n = 1'b1;
      for (int i = 0; i < RAM_WAIT + 3; i++) begin
         @(posedge clk); #1;
         check("post_reset_idle", {o_CPU_ack, o_RAM_en, o_RAM_we, o_IO_re, o_IO_we}, 0);
      end
      txn(19'h00200, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0BAD, 16'h0, 16'h0, 0);

      // Randomized traffic across all regions
      for (int t = 0; t < 150; t++) begin
         int          r;
         logic [18:0] a;
         r = int'($urandom_range(0, 3));
         case (r)
            0:       a = 19'(IO_BASE + int'($urandom_range(0, 255)));
            1:       a = 19'($urandom_range(0, BIOS_TOP - 1));
            default: a = 19'($urandom);
         endcase
         txn(a, 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom), int'($urandom_range(0, IO_TIMEOUT + 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
